// File: rtl/float_mul_arbiter_pkg.sv
// Shared float parameters for the multiplier arbiter block.
//   FLOAT_WIDTH / EXPONENT_WIDTH / MANTISSA_WIDTH : IEEE-754 single-precision layout
//   arb_state_e                                  : arbiter FSM state encoding
//   grant_width()                                : width of a requester index (GRANT_W)
package float_mul_arbiter_pkg;

  localparam int unsigned FLOAT_WIDTH    = 32;
  localparam int unsigned EXPONENT_WIDTH = 8;
  localparam int unsigned MANTISSA_WIDTH = 23;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // GRANT_W = $clog2(NUM_REQ), never narrower than one bit.
  function automatic int unsigned grant_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/float_mul_arbiter_rr_priority_pick.sv
// Combinational round-robin picker.
//   req_i     : request vector, one bit per requester
//   rr_ptr_i  : highest-priority requester index for this pick
//   grant_o   : first set request at or above rr_ptr_i, wrapping around
//   any_req_o : at least one request is set (grant_o is meaningless otherwise)
module rr_priority_pick
  import float_mul_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GRANT_W = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] rr_ptr_i,
  output logic [GRANT_W-1:0] grant_o,
  output logic               any_req_o
);

  logic [GRANT_W-1:0] idx;

  // Walk offsets from the far end down to zero so the smallest offset from
  // rr_ptr_i (the highest priority) is the last assignment and wins.
  always_comb begin
    grant_o   = '0;
    idx       = '0;
    any_req_o = |req_i;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = GRANT_W'((int'(rr_ptr_i) + k) % int'(NUM_REQ));
      if (req_i[idx]) begin
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/float_mul_arbiter.sv
// Shares one multi-cycle float multiplier between NUM_REQ requesters.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_a/req_b  : per-requester request and packed operands (slice i = requester i)
//   req_ready              : one-hot accept pulse to the granted requester
//   resp_valid/resp_data   : one-hot result pulse and the shared result bus
//   mul_req/mul_a/mul_b    : single-cycle request and held operands to the multiplier
//   mul_ack/mul_out        : multiplier done pulse and result
//   busy                   : arbiter is not idle
//   err_timeout            : sticky flag, multiplier took TIMEOUT cycles or more in WAIT
module float_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned FLOAT_WIDTH = float_mul_arbiter_pkg::FLOAT_WIDTH,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [FLOAT_WIDTH-1:0]         resp_data,
  output logic                           mul_req,
  output logic [FLOAT_WIDTH-1:0]         mul_a,
  output logic [FLOAT_WIDTH-1:0]         mul_b,
  input  logic                           mul_ack,
  input  logic [FLOAT_WIDTH-1:0]         mul_out,
  output logic                           busy,
  output logic                           err_timeout
);

  import float_mul_arbiter_pkg::*;

  localparam int unsigned GRANT_W = grant_width(NUM_REQ);
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [GRANT_W-1:0] LAST_REQ    = GRANT_W'(NUM_REQ - 1);

  arb_state_e               state_q;
  logic [GRANT_W-1:0]       rr_ptr_q;
  logic [GRANT_W-1:0]       grant_q;
  logic [CNT_W-1:0]         wait_cnt_q;
  logic [NUM_REQ-1:0]       req_ready_q;
  logic [NUM_REQ-1:0]       resp_valid_q;
  logic [FLOAT_WIDTH-1:0]   resp_data_q;
  logic                     mul_req_q;
  logic [FLOAT_WIDTH-1:0]   mul_a_q;
  logic [FLOAT_WIDTH-1:0]   mul_b_q;
  logic                     busy_q;
  logic                     err_q;

  logic [GRANT_W-1:0]     pick_grant;
  logic                   pick_any;
  logic [FLOAT_WIDTH-1:0] sel_a;
  logic [FLOAT_WIDTH-1:0] sel_b;
  logic [NUM_REQ-1:0]     pick_oh;
  logic [NUM_REQ-1:0]     grant_oh;
  logic [CNT_W-1:0]       wait_cnt_inc;
  logic [GRANT_W-1:0]     rr_ptr_next;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_pick (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (pick_grant),
    .any_req_o (pick_any)
  );

  // Operand mux for the candidate winner and one-hot forms of the new and the held grant.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    pick_oh  = '0;
    grant_oh = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_grant == GRANT_W'(i)) begin
        sel_a      = req_a[i*FLOAT_WIDTH +: FLOAT_WIDTH];
        sel_b      = req_b[i*FLOAT_WIDTH +: FLOAT_WIDTH];
        pick_oh[i] = 1'b1;
      end
      grant_oh[i] = (grant_q == GRANT_W'(i));
    end
  end

  assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);
  assign rr_ptr_next  = (grant_q == LAST_REQ) ? '0 : grant_q + GRANT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      wait_cnt_q   <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      mul_req_q    <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Pulse outputs drop unless a state below raises them this cycle.
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      mul_req_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            grant_q     <= pick_grant;
            mul_a_q     <= sel_a;
            mul_b_q     <= sel_b;
            req_ready_q <= pick_oh;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          mul_req_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          // Watchdog only flags; the operation is never abandoned.
          if (wait_cnt_q != TIMEOUT_CNT) begin
            wait_cnt_q <= wait_cnt_inc;
            if (wait_cnt_inc == TIMEOUT_CNT) begin
              err_q <= 1'b1;
            end
          end
          // Result is raised straight from the ack so it appears one cycle later.
          if (mul_ack) begin
            resp_data_q  <= mul_out;
            resp_valid_q <= grant_oh;
            state_q      <= StResp;
          end
        end
        StResp: begin
          rr_ptr_q <= rr_ptr_next;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign mul_req     = mul_req_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_float_mul_arbiter.sv
// Directed bench for float_mul_arbiter with a behavioural multiplier model.
module tb_float_mul_arbiter;

  localparam int NR = 4;
  localparam int FW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*FW-1:0] req_a;
  logic [NR*FW-1:0] req_b;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   resp_valid;
  logic [FW-1:0]   resp_data;
  logic            mul_req;
  logic [FW-1:0]   mul_a;
  logic [FW-1:0]   mul_b;
  logic            mul_ack;
  logic [FW-1:0]   mul_out;
  logic            busy;
  logic            err_timeout;

  always #5 clk = ~clk;

  float_mul_arbiter #(
    .NUM_REQ     (NR),
    .FLOAT_WIDTH (FW),
    .TIMEOUT     (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .mul_req     (mul_req),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_ack     (mul_ack),
    .mul_out     (mul_out),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // Products for the operand pairs used below, worked out by hand.
  function automatic logic [31:0] product(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;  // 2 * 3 = 6
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;  // 1 * 1
      {32'h3F800000, 32'h40000000}: return 32'h40000000;  // 1 * 2
      {32'h3F800000, 32'h40400000}: return 32'h40400000;  // 1 * 3
      {32'h3F800000, 32'h40800000}: return 32'h40800000;  // 1 * 4
      {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;  // 1.5 * 1.5 = 2.25
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Multiplier model: one op in flight, acks model_lat cycles after mul_req.
  int          model_lat = 3;
  int          stab_viol = 0;
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_ack_q;
  logic [31:0] m_out_q;
  logic        force_ack;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      m_ack_q <= 1'b0;
      m_out_q <= 32'h0;
    end else begin
      m_ack_q <= 1'b0;
      if (m_busy) begin
        if (mul_a !== m_a || mul_b !== m_b) stab_viol <= stab_viol + 1;
        if (m_cnt == 0) begin
          m_ack_q <= 1'b1;
          m_out_q <= product(m_a, m_b);
          m_busy  <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (mul_req) begin
        m_busy <= 1'b1;
        m_cnt  <= model_lat - 1;
        m_a    <= mul_a;
        m_b    <= mul_b;
      end
    end
  end

  assign mul_ack = m_ack_q | force_ack;
  assign mul_out = force_ack ? 32'hBAD0BAD0 : m_out_q;

  int          n_vec  = 0;
  int          n_fail = 0;
  int          gq[$];
  int          rq_lane[$];
  logic [31:0] rq_data[$];
  int          mulreq_cnt;

  function automatic int oh2idx(input logic [NR-1:0] oh);
    for (int i = 0; i < NR; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: log grants, results and mul_req pulses at the falling edge.
  task automatic step(input bit keep);
    @(negedge clk);
    if (|req_ready) begin
      gq.push_back(oh2idx(req_ready));
      if (!keep) req_valid = req_valid & ~req_ready;
    end
    if (|resp_valid) begin
      rq_lane.push_back(oh2idx(resp_valid));
      rq_data.push_back(resp_data);
    end
    if (mul_req) mulreq_cnt++;
  endtask

  task automatic clear_logs();
    gq.delete();
    rq_lane.delete();
    rq_data.delete();
    mulreq_cnt = 0;
  endtask

  task automatic wait_resps(input int n, input bit keep, input int budget, input string tag);
    int c = 0;
    while (rq_lane.size() < n && c < budget) begin
      step(keep);
      c++;
    end
    check(tag, 32'(rq_lane.size()), 32'(n));
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*FW +: FW] = a;
    req_b[i*FW +: FW] = b;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_ready"},  32'(req_ready),   32'h0);
    check({pfx, "_resp_valid"}, 32'(resp_valid),  32'h0);
    check({pfx, "_resp_data"},  resp_data,        32'h0);
    check({pfx, "_mul_req"},    32'(mul_req),     32'h0);
    check({pfx, "_mul_a"},      mul_a,            32'h0);
    check({pfx, "_mul_b"},      mul_b,            32'h0);
    check({pfx, "_busy"},       32'(busy),        32'h0);
    check({pfx, "_err"},        32'(err_timeout), 32'h0);
  endtask

  int          exp_lane[5] = '{0, 1, 2, 3, 0};
  logic [31:0] lane_b[4]   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] lane_p[4]   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  initial begin
    int w;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    force_ack = 1'b0;
    clear_logs();

    // Reset state
    repeat (3) step(0);
    check_all_zero("reset");
    rst = 1'b0;
    step(0);

    // Single request on lane 0: 2.0 * 3.0
    clear_logs();
    set_lane(0, 32'h40000000, 32'h40400000);
    req_valid = 4'b0001;
    step(0);
    check("t1_req_ready", 32'(req_ready), 32'h1);
    check("t1_mul_a", mul_a, 32'h40000000);
    check("t1_mul_b", mul_b, 32'h40400000);
    step(0);
    check("t1_mul_req", 32'(mul_req), 32'h1);
    wait_resps(1, 0, 50, "t1_resp_count");
    check("t1_lane", 32'(rq_lane.size() > 0 ? rq_lane[0] : -1), 32'h0);
    check("t1_data", rq_data.size() > 0 ? rq_data[0] : 32'hxxxxxxxx, 32'h40C00000);
    step(0);
    check("t1_mulreq_pulses", 32'(mulreq_cnt), 32'h1);
    check("t1_busy_after", 32'(busy), 32'h0);

    // Four lanes requesting continuously from a fresh pointer
    rst = 1'b1;
    repeat (2) step(0);
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < NR; i++) set_lane(i, 32'h3F800000, lane_b[i]);
    req_valid = 4'b1111;
    wait_resps(5, 1, 200, "t2_resp_count");
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_grant%0d", i), 32'(gq.size() > i ? gq[i] : -1), 32'(exp_lane[i]));
      check($sformatf("t2_resp_lane%0d", i), 32'(rq_lane.size() > i ? rq_lane[i] : -1),
            32'(exp_lane[i]));
      check($sformatf("t2_resp_data%0d", i),
            rq_data.size() > i ? rq_data[i] : 32'hxxxxxxxx, lane_p[exp_lane[i]]);
    end
    repeat (5) step(0);
    check("t2_operand_stability", 32'(stab_viol), 32'h0);
    check("t2_busy_after", 32'(busy), 32'h0);

    // Serve lane 3 so the pointer wraps to 0, then lanes 1 and 3 together
    clear_logs();
    set_lane(3, 32'h3F800000, 32'h40800000);
    req_valid = 4'b1000;
    wait_resps(1, 0, 50, "t3_solo_count");
    check("t3_solo_lane", 32'(rq_lane.size() > 0 ? rq_lane[0] : -1), 32'h3);
    step(0);
    clear_logs();
    set_lane(1, 32'h3FC00000, 32'h3FC00000);
    req_valid = 4'b1010;
    wait_resps(2, 0, 100, "t3_pair_count");
    check("t3_first_grant", 32'(gq.size() > 0 ? gq[0] : -1), 32'h1);
    check("t3_first_lane", 32'(rq_lane.size() > 0 ? rq_lane[0] : -1), 32'h1);
    check("t3_first_data", rq_data.size() > 0 ? rq_data[0] : 32'hxxxxxxxx, 32'h40100000);
    check("t3_second_grant", 32'(gq.size() > 1 ? gq[1] : -1), 32'h3);
    check("t3_second_data", rq_data.size() > 1 ? rq_data[1] : 32'hxxxxxxxx, 32'h40800000);
    step(0);

    // Slow multiplier: watchdog fires but the late result still returns
    clear_logs();
    model_lat = 300;
    set_lane(2, 32'h40000000, 32'h40400000);
    req_valid = 4'b0100;
    w = 0;
    while (gq.size() == 0 && w < 10) begin
      step(0);
      w++;
    end
    check("t4_granted", 32'(gq.size()), 32'h1);
    step(0);
    check("t4_mul_req", 32'(mul_req), 32'h1);
    repeat (249) step(0);
    check("t4_err_before_timeout", 32'(err_timeout), 32'h0);
    repeat (10) step(0);
    check("t4_err_after_timeout", 32'(err_timeout), 32'h1);
    check("t4_busy_waiting", 32'(busy), 32'h1);
    wait_resps(1, 0, 200, "t4_resp_count");
    check("t4_lane", 32'(rq_lane.size() > 0 ? rq_lane[0] : -1), 32'h2);
    check("t4_data", rq_data.size() > 0 ? rq_data[0] : 32'hxxxxxxxx, 32'h40C00000);
    step(0);
    check("t4_err_sticky", 32'(err_timeout), 32'h1);

    // Reset during WAIT, stale ack, then a normal request
    clear_logs();
    model_lat = 10;
    set_lane(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    step(0);
    step(0);
    repeat (3) step(0);
    rst = 1'b1;
    step(0);
    check_all_zero("t5_reset");
    rst = 1'b0;
    force_ack = 1'b1;
    step(0);
    force_ack = 1'b0;
    repeat (20) step(0);
    check("t5_no_stale_resp", 32'(rq_lane.size()), 32'h0);
    check("t5_idle", 32'(busy), 32'h0);
    check("t5_data_untouched", resp_data, 32'h0);
    set_lane(1, 32'h3F800000, 32'h40400000);
    req_valid = 4'b0010;
    wait_resps(1, 0, 50, "t5_resp_count");
    check("t5_lane", 32'(rq_lane.size() > 0 ? rq_lane[0] : -1), 32'h1);
    check("t5_data", rq_data.size() > 0 ? rq_data[0] : 32'hxxxxxxxx, 32'h40400000);
    step(0);

    // Spurious ack while idle
    clear_logs();
    force_ack = 1'b1;
    step(0);
    force_ack = 1'b0;
    repeat (3) step(0);
    check("t6_no_resp", 32'(rq_lane.size()), 32'h0);
    check("t6_idle", 32'(busy), 32'h0);
    check("t6_no_mul_req", 32'(mulreq_cnt), 32'h0);
    check("t6_data_held", resp_data, 32'h40400000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/float_mul_arbiter.md
Name: float_mul_arbiter

Overview:
- Shares one single-precision float multiplier (req/ack handshake, multi-cycle, one operation in flight) between NUM_REQ independent requesters.
- Uses round-robin arbitration, holds operands stable for the whole operation, and routes the result back to the winning requester.
- Raises a sticky watchdog flag if the multiplier fails to acknowledge within TIMEOUT cycles.
- Sits between the shader-lane issue logic and the shared multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FLOAT_WIDTH, 32, operand/result width.
- TIMEOUT, 255, max cycles in WAIT before err_timeout is set.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_a  in  NUM_REQ*FLOAT_WIDTH  packed operand A; slice i belongs to requester i
- req_b  in  NUM_REQ*FLOAT_WIDTH  packed operand B
- req_ready  out  NUM_REQ  one-hot accept pulse
- resp_valid  out  NUM_REQ  one-hot result pulse
- resp_data  out  FLOAT_WIDTH  result, valid when any resp_valid bit is high
- mul_req  out  1  request to shared multiplier
- mul_a  out  FLOAT_WIDTH  operand A to multiplier
- mul_b  out  FLOAT_WIDTH  operand B to multiplier
- mul_ack  in  1  one-cycle done pulse from multiplier
- mul_out  in  FLOAT_WIDTH  multiplier result, valid with mul_ack
- busy  out  1  high whenever state != IDLE
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst high at clk edge) sets:
  - state=IDLE, rr_ptr=0, wait_cnt=0
  - req_ready=0, resp_valid=0, resp_data=0, mul_req=0, mul_a=0, mul_b=0, err_timeout=0
- Reset mid-operation abandons the operation; no resp_valid is produced.
- The parent drives the multiplier's reset from the same source, so both blocks restart together.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward, with wrap-around.
  - Latch req_a/req_b slice into mul_a/mul_b and record grant id.
  - Pulse req_ready[grant] for exactly one cycle, then go to ISSUE.
  - A requester must hold valid/operands until it sees req_ready.
- ISSUE: mul_req=1 for exactly one cycle; wait_cnt=0; go to WAIT.
- WAIT:
  - mul_req=0; mul_a/mul_b stay stable until mul_ack.
  - wait_cnt increments each cycle, saturating at TIMEOUT.
  - On reaching TIMEOUT, set err_timeout; keep waiting, never abandon the operation.
  - On mul_ack: resp_data<=mul_out; go to RESP.
- RESP:
  - resp_valid[grant]=1 for one cycle; rr_ptr<=grant+1 modulo NUM_REQ; go to IDLE.
- Latency: accept→mul_req is 1 cycle. mul_ack→resp_valid is 1 cycle. Back-to-back throughput is one operation per (multiplier latency + 3) cycles.
- mul_ack outside WAIT is ignored. It must not change state or data.
- req_valid withdrawn before acceptance: no grant; rr_ptr is unchanged.
- Simultaneous requests: exactly one winner per operation. A continuously requesting lane waits at most NUM_REQ-1 operations.
- err_timeout clears only on rst.

Decomposition:
- Shared package (float_params): FLOAT_WIDTH, EXPONENT_WIDTH=8, MANTISSA_WIDTH=23, arbiter state encoding enum, GRANT_W=$clog2(NUM_REQ).
- One sub-module: rr_priority_pick (combinational round-robin picker).
  - Inputs: req vector, rr_ptr.
  - Outputs: grant id and any_req.

Test Plan:
- Single request, lane 0, a=0x40000000, b=0x40400000 → req_ready[0] 1 cycle later, one mul_req pulse, resp_valid[0] with resp_data=0x40C00000; busy low afterwards.
- All 4 lanes request continuously with distinct operands (lane i: a=0x3F800000, b=i+1 as float) → grants in order 0,1,2,3,0. Each resp_valid[i] carries the matching product; mul_a/mul_b are stable from ISSUE until mul_ack.
- Lanes 1 and 3 request after lane 3 was last served → lane 1 is granted first. Then 1.5*1.5 (0x3FC00000²) returns 0x40100000 on lane 1.
- Multiplier model withholds mul_ack for 300 cycles, TIMEOUT=255 → err_timeout rises at cycle 255 of WAIT and stays high. The late ack still yields resp_valid with correct data.
- rst asserted while in WAIT → next cycle all outputs are 0 and state is IDLE. A stale mul_ack after reset produces no resp_valid. A new request then completes normally.
- Spurious mul_ack pulse in IDLE → no state change, no resp_valid, and resp_data holds its previous value.
